// File: rtl/bus_router.sv
// Single-master bus router: decodes the request address into one of NUM_SLAVES regions,
// steers byte lanes, waits for the slave, and issues a one-cycle response or error.
module bus_router #(
    parameter int NUM_SLAVES = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE = {32'h0000_1000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SIZE = {32'hFFFF_F000, 32'h0000_1000},
    parameter int TIMEOUT    = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [1:0]                   req_size,
    input  logic                         req_signed,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    output logic                         resp_valid,
    output logic [DATA_W-1:0]            resp_rdata,
    output logic                         resp_err,
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic                         s_we,
    output logic [3:0]                   s_be,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ready,
    output logic [ADDR_W-1:0]            fault_addr,
    output logic [7:0]                   fault_count
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  r_state;
    logic [ADDR_W-1:0]       r_addr;
    logic [1:0]              r_size;
    logic                    r_signed;
    logic                    r_we;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_req_ready;
    logic                    r_resp_valid;
    logic [DATA_W-1:0]       r_resp_rdata;
    logic                    r_resp_err;
    logic [NUM_SLAVES-1:0]   r_sel;
    logic                    r_s_we;
    logic [3:0]              r_s_be;
    logic [ADDR_W-1:0]       r_s_addr;
    logic [DATA_W-1:0]       r_s_wdata;
    logic [ADDR_W-1:0]       r_fault_addr;
    logic [7:0]              r_fault_count;

    logic [NUM_SLAVES-1:0]   w_hit_vec;
    logic [NUM_SLAVES-1:0]   w_hit_onehot;
    logic                    w_hit_any;
    logic [ADDR_W-1:0]       w_hit_base;
    logic                    w_misaligned;
    logic                    w_decode_err;
    logic [3:0]              w_be;
    logic [DATA_W-1:0]       w_wdata;
    logic [DATA_W-1:0]       w_sel_word;
    logic [DATA_W-1:0]       w_shifted;
    logic [DATA_W-1:0]       w_load_data;
    logic                    w_slave_done;
    logic                    w_timeout;
    logic                    w_fault;
    logic [ADDR_W-1:0]       w_fault_addr_next;

    // Region match: address with the region's offset bits masked must equal the base.
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_hit
        localparam logic [ADDR_W-1:0] G_BASE = BASE[gi*ADDR_W +: ADDR_W];
        localparam logic [ADDR_W-1:0] G_MASK = ~(SIZE[gi*ADDR_W +: ADDR_W] - ADDR_W'(1));
        assign w_hit_vec[gi] = (req_addr & G_MASK) == G_BASE;
    end

    // Isolating the lowest set bit gives lowest-index priority on overlapping regions.
    assign w_hit_onehot = w_hit_vec & (~w_hit_vec + NUM_SLAVES'(1));
    assign w_hit_any    = |w_hit_vec;

    always_comb begin
        w_hit_base = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_hit_onehot[i]) w_hit_base = BASE[i*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        case (req_size)
            2'd0:    begin w_misaligned = 1'b0;           w_be = 4'b0001 << req_addr[1:0]; w_wdata = {4{req_wdata[7:0]}};  end
            2'd1:    begin w_misaligned = req_addr[0];    w_be = 4'b0011 << req_addr[1:0]; w_wdata = {2{req_wdata[15:0]}}; end
            2'd2:    begin w_misaligned = |req_addr[1:0]; w_be = 4'b1111;                  w_wdata = req_wdata;            end
            default: begin w_misaligned = 1'b1;           w_be = 4'b1111;                  w_wdata = req_wdata;            end
        endcase
    end

    assign w_decode_err = w_misaligned || !w_hit_any;

    always_comb begin
        w_sel_word = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_sel[i]) w_sel_word = s_rdata[i*DATA_W +: DATA_W];
        end
    end

    assign w_shifted = w_sel_word >> {r_addr[1:0], 3'b000};

    always_comb begin
        case (r_size)
            2'd0:    w_load_data = {{24{r_signed & w_shifted[7]}},  w_shifted[7:0]};
            2'd1:    w_load_data = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    assign w_slave_done = |(s_ready & r_sel);
    assign w_timeout    = (r_cnt == CNT_LAST);

    assign w_fault = ((r_state == S_IDLE) && req_valid && w_decode_err) ||
                     ((r_state == S_WAIT) && !w_slave_done && w_timeout);
    assign w_fault_addr_next = (r_state == S_IDLE) ? req_addr : r_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_we         <= 1'b0;
            r_cnt        <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_sel        <= '0;
            r_s_we       <= 1'b0;
            r_s_be       <= '0;
            r_s_addr     <= '0;
            r_s_wdata    <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr      <= req_addr;
                        r_size      <= req_size;
                        r_signed    <= req_signed;
                        r_we        <= req_we;
                        r_cnt       <= '0;
                        r_req_ready <= 1'b0;
                        if (w_decode_err) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_state   <= S_WAIT;
                            r_sel     <= w_hit_onehot;
                            r_s_we    <= req_we;
                            r_s_be    <= w_be;
                            r_s_addr  <= req_addr - w_hit_base;
                            r_s_wdata <= w_wdata;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_slave_done || w_timeout) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= !w_slave_done;
                        r_resp_rdata <= (w_slave_done && !r_we) ? w_load_data : '0;
                        r_sel        <= '0;
                        r_s_we       <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_sel       <= '0;
                    r_s_we      <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault_addr  <= '0;
            r_fault_count <= '0;
        end else if (w_fault) begin
            r_fault_addr <= w_fault_addr_next;
            if (r_fault_count != 8'hFF) r_fault_count <= r_fault_count + 8'd1;
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
    assign resp_err    = r_resp_err;
    assign s_sel       = r_sel;
    assign s_we        = r_s_we;
    assign s_be        = r_s_be;
    assign s_addr      = r_s_addr;
    assign s_wdata     = r_s_wdata;
    assign fault_addr  = r_fault_addr;
    assign fault_count = r_fault_count;

endmodule

// File: tb/tb_bus_router.sv
// Bench for bus_router: directed requests, a transaction-level expectation model checked
// every cycle, and literal expectations for the headline scenarios.
module tb_bus_router;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam logic [N*AW-1:0] BASE_P = {32'h0000_1000, 32'h0000_0000};
    localparam logic [N*AW-1:0] SIZE_P = {32'hFFFF_F000, 32'h0000_1000};

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_we = 1'b0;
    logic [1:0]      req_size = 2'd0;
    logic            req_signed = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic [DW-1:0]   req_wdata = '0;
    logic            resp_valid;
    logic [DW-1:0]   resp_rdata;
    logic            resp_err;
    logic [N-1:0]    s_sel;
    logic            s_we;
    logic [3:0]      s_be;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [N*DW-1:0] s_rdata;
    logic [N-1:0]    s_ready = '0;
    logic [AW-1:0]   fault_addr;
    logic [7:0]      fault_count;

    logic [31:0] slave_word [N];

    bus_router #(
        .NUM_SLAVES(N), .ADDR_W(AW), .DATA_W(DW),
        .BASE(BASE_P), .SIZE(SIZE_P), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .s_sel(s_sel), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .fault_addr(fault_addr), .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    assign s_rdata = {slave_word[1], slave_word[0]};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Expectation for the single outstanding transaction
    int            cyc = 0;
    bit            active = 1'b0;
    bit            exp_pending = 1'b0;
    int            exp_acc = 0;
    int            exp_resp = 0;
    bit            exp_mapped = 1'b0;
    bit            exp_err = 1'b0;
    logic          exp_we = 1'b0;
    logic [31:0]   exp_rdata = '0;
    logic [31:0]   exp_addr = '0;
    logic [31:0]   exp_saddr = '0;
    logic [31:0]   exp_swdata = '0;
    logic [3:0]    exp_be = '0;
    logic [N-1:0]  exp_sel = '0;
    logic [31:0]   m_fault_addr = '0;
    int            m_fault_cnt = 0;

    int            sel_cnt = 0;
    int            n_resp = 0;
    int            last_ofs = -1;
    logic [31:0]   last_rdata = '0;
    logic          last_err = 1'b0;
    logic [N-1:0]  last_sel = '0;
    logic [3:0]    last_be = '0;
    logic [31:0]   last_saddr = '0;
    logic [31:0]   last_swdata = '0;
    logic          last_swe = 1'b0;

    // Slave responder: the selected slave answers after slv_dly extra wait cycles;
    // non-selected slaves assert s_ready when other_ready is set.
    int slv_dly = 0;
    bit other_ready = 1'b0;
    int wcnt = 0;
    always @(negedge clk) begin
        if (s_sel != '0) wcnt = wcnt + 1;
        else wcnt = 0;
        s_ready = (((s_sel != '0) && (wcnt > slv_dly)) ? s_sel : '0) |
                  (other_ready ? ~s_sel : '0);
    end

    always @(posedge clk) begin
        bit in_txn;
        bit rv;
        logic [N-1:0] sel_e;
        cyc = cyc + 1;
        #2;
        if (active) begin
            in_txn = exp_pending && (cyc >= exp_acc) && (cyc <= exp_resp);
            rv     = exp_pending && (cyc == exp_resp);
            sel_e  = (exp_pending && exp_mapped && (cyc >= exp_acc) && (cyc < exp_resp)) ? exp_sel : '0;
            if (rv && exp_err) begin
                m_fault_addr = exp_addr;
                if (m_fault_cnt < 255) m_fault_cnt = m_fault_cnt + 1;
            end
            if (resp_valid) n_resp++;
            chk("req_ready", 32'(req_ready), 32'(!in_txn));
            chk("resp_valid", 32'(resp_valid), 32'(rv));
            chk("s_sel", 32'(s_sel), 32'(sel_e));
            chk("fault_addr", fault_addr, m_fault_addr);
            chk("fault_count", 32'(fault_count), 32'(m_fault_cnt));
            if (rv) begin
                chk("resp_err", 32'(resp_err), 32'(exp_err));
                chk("resp_rdata", resp_rdata, exp_rdata);
                last_rdata = resp_rdata;
                last_err   = resp_err;
                last_ofs   = cyc - exp_acc;
            end
            if (sel_e != '0) begin
                sel_cnt++;
                chk("s_we", 32'(s_we), 32'(exp_we));
                chk("s_be", 32'(s_be), 32'(exp_be));
                chk("s_addr", s_addr, exp_saddr);
                chk("s_wdata", s_wdata, exp_swdata);
                last_sel    = s_sel;
                last_be     = s_be;
                last_saddr  = s_addr;
                last_swdata = s_wdata;
                last_swe    = s_we;
            end
        end
    end

    // Present a request at a negedge while the router is idle and predict its outcome.
    task automatic start_req(input logic we, input logic [1:0] sz, input logic sg,
                             input logic [31:0] addr, input logic [31:0] wd, input int dly);
        logic        mis;
        int          hit;
        int          off;
        logic [31:0] v;
        slv_dly = dly;
        mis = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
        hit = -1;
        for (int k = N - 1; k >= 0; k--) begin
            if ((addr & ~(SIZE_P[k*AW +: AW] - 32'd1)) == BASE_P[k*AW +: AW]) hit = k;
        end
        off        = int'(addr[1:0]);
        exp_acc    = cyc + 1;
        exp_addr   = addr;
        exp_we     = we;
        exp_mapped = !mis && (hit >= 0);
        exp_rdata  = '0;
        if (!exp_mapped) begin
            exp_err  = 1'b1;
            exp_resp = exp_acc;
        end else if (dly >= TO) begin
            exp_err  = 1'b1;
            exp_resp = exp_acc + TO;
        end else begin
            exp_err  = 1'b0;
            exp_resp = exp_acc + 1 + dly;
            v = slave_word[hit] >> (8 * off);
            if (we) exp_rdata = '0;
            else if (sz == 2'd0) begin
                exp_rdata = {24'h0, v[7:0]};
                if (sg && v[7]) exp_rdata[31:8] = '1;
            end else if (sz == 2'd1) begin
                exp_rdata = {16'h0, v[15:0]};
                if (sg && v[15]) exp_rdata[31:16] = '1;
            end else exp_rdata = slave_word[hit];
        end
        if (exp_mapped) begin
            exp_sel    = N'(1) << hit;
            exp_saddr  = addr - BASE_P[hit*AW +: AW];
            exp_be     = (sz == 2'd0) ? (4'b0001 << off) : (sz == 2'd1) ? (4'b0011 << off) : 4'b1111;
            exp_swdata = (sz == 2'd0) ? {4{wd[7:0]}} : (sz == 2'd1) ? {2{wd[15:0]}} : wd;
        end
        sel_cnt     = 0;
        exp_pending = 1'b1;
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hDEAD_BEEF;
        req_wdata = 32'h5555_AAAA;
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd, input int dly);
        start_req(we, sz, sg, addr, wd, dly);
        while (cyc <= exp_resp) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nr;
        slave_word[0] = 32'hA1B2_C3D4;
        slave_word[1] = 32'h80FF_0000;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_s_sel", 32'(s_sel), 32'd0);
        chk("rst_s_we", 32'(s_we), 32'd0);
        chk("rst_s_be", 32'(s_be), 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_s_wdata", s_wdata, 32'd0);
        chk("rst_fault", {24'h0, fault_count} | fault_addr, 32'd0);
        reset  = 1'b0;
        active = 1'b1;
        @(negedge clk);

        issue(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 0);
        chk("t1_rdata", last_rdata, 32'hA1B2_C3D4);
        chk("t1_err", 32'(last_err), 32'd0);
        chk("t1_resp_ofs", 32'(last_ofs), 32'd1);
        chk("t1_sel_cycles", 32'(sel_cnt), 32'd1);
        chk("t1_sel", 32'(last_sel), 32'h1);
        chk("t1_saddr", last_saddr, 32'h10);

        issue(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0, 0);
        chk("sbyte_rdata", last_rdata, 32'hFFFF_FF80);
        chk("sbyte_saddr", last_saddr, 32'h3);
        chk("sbyte_be", 32'(last_be), 32'h8);
        issue(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 0);
        chk("ubyte_rdata", last_rdata, 32'h0000_0080);

        issue(1'b1, 2'd1, 1'b0, 32'h0000_1002, 32'hABCD_1234, 0);
        chk("hst_sel", 32'(last_sel), 32'h2);
        chk("hst_be", 32'(last_be), 32'hC);
        chk("hst_wdata", last_swdata, 32'h1234_1234);
        chk("hst_we", 32'(last_swe), 32'd1);
        chk("hst_rdata", last_rdata, 32'd0);

        issue(1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'h0000_005A, 0);
        chk("bst_be", 32'(last_be), 32'h2);
        chk("bst_wdata", last_swdata, 32'h5A5A_5A5A);
        issue(1'b0, 2'd0, 1'b1, 32'h0000_0002, 32'h0, 1);
        chk("sbyte0_rdata", last_rdata, 32'hFFFF_FFB2);
        chk("sbyte0_resp_ofs", 32'(last_ofs), 32'd2);

        issue(1'b0, 2'd1, 1'b1, 32'h0000_1002, 32'h0, 3);
        chk("shalf_rdata", last_rdata, 32'hFFFF_80FF);
        chk("shalf_resp_ofs", 32'(last_ofs), 32'd4);

        other_ready = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 32'h0000_1004, 32'h0, TO - 1);
        chk("lastwait_err", 32'(last_err), 32'd0);
        chk("lastwait_rdata", last_rdata, 32'h80FF_0000);
        chk("lastwait_resp_ofs", 32'(last_ofs), 32'd8);

        issue(1'b0, 2'd2, 1'b0, 32'h0000_1008, 32'h0, TO);
        chk("tmo_err", 32'(last_err), 32'd1);
        chk("tmo_rdata", last_rdata, 32'd0);
        chk("tmo_resp_ofs", 32'(last_ofs), 32'd8);
        chk("tmo_sel_cycles", 32'(sel_cnt), 32'd8);
        chk("tmo_fault_addr", fault_addr, 32'h0000_1008);
        chk("tmo_fault_count", 32'(fault_count), 32'd1);
        other_ready = 1'b0;

        issue(1'b0, 2'd2, 1'b0, 32'h0000_2000, 32'h0, 0);
        chk("unmap_err", 32'(last_err), 32'd1);
        chk("unmap_resp_ofs", 32'(last_ofs), 32'd0);

        issue(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 0);
        chk("mis_err", 32'(last_err), 32'd1);
        chk("mis_sel_cycles", 32'(sel_cnt), 32'd0);
        chk("mis_fault_addr", fault_addr, 32'h6);
        chk("mis_fault_count", 32'(fault_count), 32'd3);
        issue(1'b0, 2'd1, 1'b0, 32'h0000_1001, 32'h0, 0);
        issue(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 0);
        chk("size3_err", 32'(last_err), 32'd1);

        for (int i = 0; i < 300; i++) issue(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 0);
        chk("sat_fault_count", 32'(fault_count), 32'd255);
        chk("sat_fault_addr", fault_addr, 32'h6);

        start_req(1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0, 100);
        repeat (3) @(negedge clk);
        reset        = 1'b1;
        exp_pending  = 1'b0;
        m_fault_addr = '0;
        m_fault_cnt  = 0;
        nr = n_resp;
        @(negedge clk);
        chk("abort_sel", 32'(s_sel), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_fault_count", 32'(fault_count), 32'd0);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort_no_resp", 32'(n_resp), 32'(nr));

        issue(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 0);
        chk("post_rst_rdata", last_rdata, 32'hA1B2_C3D4);

        active = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
